// File: rtl/cpu_controller_if.sv
// rtl/cpu_controller_if.sv - opcode/flag inputs and datapath strobes of the CPU controller
interface cpu_controller_if #(
  parameter int ICNT_W = 8
);
  logic [2:0]        opcode;
  logic              zero;
  logic              sel;
  logic              rd;
  logic              ld_ir;
  logic              inc_pc;
  logic              ld_pc;
  logic              data_e;
  logic              ld_ac;
  logic              wr;
  logic              halt;
  logic [2:0]        phase;
  logic [ICNT_W-1:0] icount;

  // Controller side: samples opcode/zero, drives the datapath strobes
  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt, phase, icount
  );

  // Datapath side: supplies opcode/zero, consumes the strobes
  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt, phase, icount
  );
endinterface

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - eight-phase sequencer for a simple accumulator CPU
module cpu_controller #(
  parameter int ICNT_W = 8
) (
  input logic             CLK,
  input logic             RST,
  cpu_controller_if.master bus
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_t            r_phase;
  phase_t            w_phase_nxt;
  logic              r_halted;
  logic              w_halted_nxt;
  logic [ICNT_W-1:0] r_icount;
  logic [ICNT_W-1:0] w_icount_nxt;

  logic w_aluop;
  logic w_sel;
  logic w_rd;
  logic w_ld_ir;
  logic w_inc_pc;
  logic w_ld_pc;
  logic w_data_e;
  logic w_ld_ac;
  logic w_wr;
  logic w_halt;

  // Instructions that read an operand from memory into the ALU/accumulator
  assign w_aluop = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                   (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);

  // State register: phase, halted flag and retired-instruction counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_phase  <= INST_ADDR;
      r_halted <= 1'b0;
      r_icount <= '0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_halted <= w_halted_nxt;
      r_icount <= w_icount_nxt;
    end
  end

  // Next state: step the phase, stop in OP_ADDR on HLT, count retired instructions
  always_comb begin
    w_phase_nxt  = r_phase;
    w_halted_nxt = r_halted;
    w_icount_nxt = r_icount;
    if (!r_halted) begin
      if ((r_phase == OP_ADDR) && (bus.opcode == OP_HLT)) begin
        // Phase stays at OP_ADDR so a halted CPU reports where it stopped
        w_halted_nxt = 1'b1;
      end else begin
        w_phase_nxt = phase_t'(r_phase + 3'd1);
        if ((r_phase == STORE) && (r_icount != {ICNT_W{1'b1}})) begin
          w_icount_nxt = r_icount + ICNT_W'(1);
        end
      end
    end
  end

  // Output decode: strobes follow the current phase and live opcode/zero
  always_comb begin
    w_sel    = 1'b0;
    w_rd     = 1'b0;
    w_ld_ir  = 1'b0;
    w_inc_pc = 1'b0;
    w_ld_pc  = 1'b0;
    w_data_e = 1'b0;
    w_ld_ac  = 1'b0;
    w_wr     = 1'b0;
    w_halt   = 1'b0;
    if (r_halted) begin
      w_halt = 1'b1;
    end else begin
      case (r_phase)
        INST_ADDR: begin
          w_sel = 1'b1;
        end
        INST_FETCH: begin
          w_sel = 1'b1;
          w_rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          w_sel   = 1'b1;
          w_rd    = 1'b1;
          w_ld_ir = 1'b1;
        end
        OP_ADDR: begin
          w_inc_pc = 1'b1;
          w_halt   = (bus.opcode == OP_HLT);
        end
        OP_FETCH: begin
          w_rd = w_aluop;
        end
        ALU_OP: begin
          w_rd     = w_aluop;
          w_inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
          w_ld_pc  = (bus.opcode == OP_JMP);
          w_data_e = (bus.opcode == OP_STO);
        end
        STORE: begin
          // rd is only set for ALU ops and wr only for STO, so they never overlap
          w_rd     = w_aluop;
          w_ld_ac  = w_aluop;
          w_ld_pc  = (bus.opcode == OP_JMP);
          w_wr     = (bus.opcode == OP_STO);
          w_data_e = (bus.opcode == OP_STO);
        end
        default: begin
          w_sel = 1'b0;
        end
      endcase
    end
  end

  assign bus.sel    = w_sel;
  assign bus.rd     = w_rd;
  assign bus.ld_ir  = w_ld_ir;
  assign bus.inc_pc = w_inc_pc;
  assign bus.ld_pc  = w_ld_pc;
  assign bus.data_e = w_data_e;
  assign bus.ld_ac  = w_ld_ac;
  assign bus.wr     = w_wr;
  assign bus.halt   = w_halt;
  assign bus.phase  = r_phase;
  assign bus.icount = r_icount;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - scoreboard bench for cpu_controller
module tb_cpu_controller;

  localparam int ICNT_W = 8;
  localparam int ICNT_MAX = (1 << ICNT_W) - 1;

  localparam int HLT = 0, SKZ = 1, ADD = 2, AND_ = 3, XOR_ = 4, LDA = 5, STO = 6, JMP = 7;

  typedef struct packed {
    logic [2:0]        phase;
    logic [8:0]        strb;   // {sel,rd,ld_ir,inc_pc,ld_pc,data_e,ld_ac,wr,halt}
    logic [ICNT_W-1:0] icount;
  } exp_t;

  logic CLK;
  logic RST;

  cpu_controller_if #(.ICNT_W(ICNT_W)) bus ();

  cpu_controller #(.ICNT_W(ICNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model state
  int m_phase  = 0;
  int m_halted = 0;
  int m_icount = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs for the current model state and the given opcode/zero
  function automatic exp_t model_out(input int op, input bit z);
    exp_t e;
    bit   aluop;
    bit   s_sel, s_rd, s_ldir, s_incpc, s_ldpc, s_de, s_ldac, s_wr, s_halt;
    aluop = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
    {s_sel, s_rd, s_ldir, s_incpc, s_ldpc, s_de, s_ldac, s_wr, s_halt} = '0;
    if (m_halted != 0) begin
      s_halt = 1'b1;
    end else begin
      if (m_phase <= 3) s_sel = 1'b1;
      if (m_phase >= 1 && m_phase <= 3) s_rd = 1'b1;
      if (m_phase == 2 || m_phase == 3) s_ldir = 1'b1;
      if (m_phase >= 5) s_rd = aluop;
      if (m_phase == 4) begin
        s_incpc = 1'b1;
        s_halt  = (op == HLT);
      end
      if (m_phase == 6) s_incpc = (op == SKZ) && z;
      if (m_phase >= 6) begin
        s_ldpc = (op == JMP);
        s_de   = (op == STO);
      end
      if (m_phase == 7) begin
        s_ldac = aluop;
        s_wr   = (op == STO);
      end
    end
    e.phase  = 3'(m_phase);
    e.strb   = {s_sel, s_rd, s_ldir, s_incpc, s_ldpc, s_de, s_ldac, s_wr, s_halt};
    e.icount = ICNT_W'(m_icount);
    return e;
  endfunction

  // One clock cycle: drive inputs, queue the expectation, then advance the model
  task automatic step(input int op, input bit z);
    bus.opcode = 3'(op);
    bus.zero   = z;
    q.push_back(model_out(op, z));
    @(posedge CLK);
    if (!RST) begin
      m_phase = 0; m_halted = 0; m_icount = 0;
    end else if (m_halted == 0) begin
      if (m_phase == 4 && op == HLT) begin
        m_halted = 1;
      end else begin
        if (m_phase == 7 && m_icount < ICNT_MAX) m_icount++;
        m_phase = (m_phase + 1) % 8;
      end
    end
    #1;
  endtask

  task automatic instr(input int op, input bit z);
    for (int k = 0; k < 8; k++) step(op, z);
  endtask

  // Pull reset low between clock edges and check it takes effect without a clock
  task automatic async_reset_check(input string tag);
    #2;
    RST = 1'b0;
    #1;
    chk({tag, "_phase"}, bus.phase, 0);
    chk({tag, "_icount"}, bus.icount, 0);
    chk({tag, "_halt"}, bus.halt, 0);
    chk({tag, "_strobes"}, {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
                            bus.data_e, bus.ld_ac, bus.wr}, 8'b1000_0000);
    m_phase = 0; m_halted = 0; m_icount = 0;
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation
  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cyc++;
      chk("phase", bus.phase, e.phase);
      chk("strobes", {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
                      bus.data_e, bus.ld_ac, bus.wr, bus.halt}, e.strb);
      chk("icount", bus.icount, e.icount);
      chk("exclusive", (bus.wr & bus.ld_pc) | (bus.rd & bus.wr), 0);
    end
  end

  initial begin
    RST        = 1'b0;
    bus.opcode = 3'd0;
    bus.zero   = 1'b0;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) step(ADD, 1'b0);
    RST = 1'b1;

    // Directed instructions
    instr(ADD, 1'b0);
    instr(SKZ, 1'b1);
    instr(SKZ, 1'b0);
    instr(STO, 1'b0);
    instr(JMP, 1'b1);
    instr(AND_, 1'b0);
    instr(XOR_, 1'b1);
    instr(LDA, 1'b0);

    // Random non-halting instructions with random zero flag each cycle
    for (int n = 0; n < 30; n++) begin
      int op;
      op = $urandom_range(1, 7);
      for (int k = 0; k < 8; k++) step(op, 1'($urandom_range(0, 1)));
    end

    // Counter saturation, then asynchronous reset during OP_FETCH
    for (int n = 0; n < 300; n++) instr(ADD, 1'($urandom_range(0, 1)));
    for (int k = 0; k < 5; k++) step(ADD, 1'b0);
    async_reset_check("rst_mid");
    for (int k = 0; k < 2; k++) step(ADD, 1'b0);
    RST = 1'b1;
    instr(ADD, 1'b0);

    // HLT: stop in OP_ADDR and stay there regardless of inputs
    for (int k = 0; k < 5; k++) step(HLT, 1'b0);
    for (int k = 0; k < 20; k++) step($urandom_range(0, 7), 1'($urandom_range(0, 1)));
    async_reset_check("rst_halted");
    for (int k = 0; k < 2; k++) step(STO, 1'b0);
    RST = 1'b1;
    instr(STO, 1'b0);
    instr(ADD, 1'b1);

    @(negedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
